// File: rtl/traffic_cmd_scheduler_if.sv
// Command-type encoding shared with traffic_lights, plus the host-request / command-out
// handshake bundle of the scheduler.
package traffic_cmd_pkg;
    typedef enum logic [2:0] {
        CMD_OFF          = 3'd0,
        CMD_ON           = 3'd1,
        CMD_NOTRANSITION = 3'd2,
        CMD_SET_GREEN    = 3'd3,
        CMD_SET_RED      = 3'd4,
        CMD_SET_YELLOW   = 3'd5
    } command_e;
endpackage

interface traffic_cmd_scheduler_if;
    import traffic_cmd_pkg::*;

    command_e    host_type;
    logic [15:0] host_data;
    logic        host_valid;
    logic        host_ready;
    command_e    cmd_type;
    logic [15:0] cmd_data;
    logic        cmd_valid;

    // master: the scheduler; slave: host logic plus the traffic_lights command port
    modport master (
        input  host_type, host_data, host_valid,
        output host_ready, cmd_type, cmd_data, cmd_valid
    );
    modport slave (
        output host_type, host_data, host_valid,
        input  host_ready, cmd_type, cmd_data, cmd_valid
    );
endinterface

// File: rtl/traffic_cmd_scheduler.sv
// Sole command master for traffic_lights: replays the boot sequence after reset, then
// round-robins host commands against night-mode changes with a forced gap after each strobe.
module traffic_cmd_scheduler #(
    parameter int GREEN_MS   = 10000,
    parameter int RED_MS     = 10000,
    parameter int YELLOW_MS  = 2000,
    parameter int GAP_CYCLES = 4
) (
    input  logic                           clk_2k_i,
    input  logic                           arst_n_i,
    traffic_cmd_scheduler_if.master        cmd_bus,
    input  logic                           night_i,
    output logic [1:0]                     mode_o,
    output logic                           busy_o
);
    import traffic_cmd_pkg::*;

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        BOOT_GREEN,
        BOOT_RED,
        BOOT_YELLOW,
        BOOT_ON,
        IDLE,
        GAP
    } state_e;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_NIGHT = 2'd2
    } mode_e;

    typedef enum logic {
        GRANT_HOST,
        GRANT_NIGHT
    } grant_e;

    state_e      state;
    state_e      ret_state;
    logic [CNT_W-1:0] gap_cnt;
    grant_e      last_grant;
    mode_e       mode;
    logic        night_q1;
    logic        night_s;
    command_e    cmd_type_q;
    logic [15:0] cmd_data_q;
    logic        cmd_valid_q;

    logic        night_pend;
    logic        host_win;
    logic        night_win;
    logic        issue;
    command_e    issue_type;
    logic [15:0] issue_data;
    state_e      issue_ret;

    function automatic mode_e mode_after(mode_e cur, command_e t);
        case (t)
            CMD_ON:           return MODE_ON;
            CMD_OFF:          return MODE_OFF;
            CMD_NOTRANSITION: return MODE_NIGHT;
            default:          return cur;
        endcase
    endfunction

    // Night request stays pending until the issued mode matches the synchronized level.
    assign night_pend = (night_s && mode != MODE_NIGHT) || (!night_s && mode == MODE_NIGHT);
    assign host_win   = (state == IDLE) && cmd_bus.host_valid &&
                        (!night_pend || last_grant == GRANT_NIGHT);
    assign night_win  = (state == IDLE) && night_pend &&
                        (!cmd_bus.host_valid || last_grant == GRANT_HOST);

    always_comb begin
        issue      = 1'b0;
        issue_type = CMD_OFF;
        issue_data = '0;
        issue_ret  = IDLE;
        case (state)
            BOOT_GREEN: begin
                issue      = 1'b1;
                issue_type = CMD_SET_GREEN;
                issue_data = 16'(GREEN_MS);
                issue_ret  = BOOT_RED;
            end
            BOOT_RED: begin
                issue      = 1'b1;
                issue_type = CMD_SET_RED;
                issue_data = 16'(RED_MS);
                issue_ret  = BOOT_YELLOW;
            end
            BOOT_YELLOW: begin
                issue      = 1'b1;
                issue_type = CMD_SET_YELLOW;
                issue_data = 16'(YELLOW_MS);
                issue_ret  = BOOT_ON;
            end
            BOOT_ON: begin
                issue      = 1'b1;
                issue_type = CMD_ON;
                issue_ret  = IDLE;
            end
            IDLE: begin
                if (host_win) begin
                    issue      = 1'b1;
                    issue_type = cmd_bus.host_type;
                    issue_data = cmd_bus.host_data;
                end else if (night_win) begin
                    issue      = 1'b1;
                    issue_type = night_s ? CMD_NOTRANSITION : CMD_ON;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_2k_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= BOOT_GREEN;
            ret_state   <= BOOT_GREEN;
            gap_cnt     <= '0;
            last_grant  <= GRANT_HOST;
            mode        <= MODE_OFF;
            night_q1    <= 1'b0;
            night_s     <= 1'b0;
            cmd_type_q  <= CMD_OFF;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            night_q1    <= night_i;
            night_s     <= night_q1;
            cmd_valid_q <= 1'b0;
            if (issue) begin
                cmd_valid_q <= 1'b1;
                cmd_type_q  <= issue_type;
                cmd_data_q  <= issue_data;
                mode        <= mode_after(mode, issue_type);
                state       <= GAP;
                ret_state   <= issue_ret;
                gap_cnt     <= CNT_W'(GAP_CYCLES - 1);
                if (host_win) begin
                    last_grant <= GRANT_HOST;
                end else if (night_win) begin
                    last_grant <= GRANT_NIGHT;
                end
            end else if (state == GAP) begin
                if (gap_cnt == '0) begin
                    state <= ret_state;
                end else begin
                    gap_cnt <= gap_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign cmd_bus.cmd_valid  = cmd_valid_q;
    assign cmd_bus.cmd_type   = cmd_type_q;
    assign cmd_bus.cmd_data   = cmd_data_q;
    assign cmd_bus.host_ready = host_win;
    assign mode_o             = mode;
    assign busy_o             = (state != IDLE);

endmodule

// File: tb/tb_traffic_cmd_scheduler.sv
// Directed per-cycle vector table for traffic_cmd_scheduler, plus a reset-mid-GAP sequence
// followed by a replay of the boot rows.
module tb_traffic_cmd_scheduler;
    import traffic_cmd_pkg::*;

    localparam int BOOT_ROWS = 20;

    typedef struct {
        logic        hv;
        command_e    ht;
        logic [15:0] hd;
        logic        nt;
        logic        rdy;
        logic        vld;
        command_e    typ;
        logic [15:0] dat;
        logic [1:0]  md;
        logic        bz;
    } vec_t;

    logic clk;
    logic arst_n;
    logic night;
    logic [1:0] mode;
    logic busy;
    int n_vec;
    int n_fail;
    vec_t tbl[$];

    traffic_cmd_scheduler_if bus ();

    traffic_cmd_scheduler #(
        .GREEN_MS   (10000),
        .RED_MS     (10000),
        .YELLOW_MS  (2000),
        .GAP_CYCLES (4)
    ) dut (
        .clk_2k_i (clk),
        .arst_n_i (arst_n),
        .cmd_bus  (bus),
        .night_i  (night),
        .mode_o   (mode),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic void add(input logic hv, input command_e ht, input logic [15:0] hd,
                                input logic nt, input logic rdy, input logic vld,
                                input command_e typ, input logic [15:0] dat,
                                input logic [1:0] md, input logic bz);
        vec_t v;
        v.hv = hv; v.ht = ht; v.hd = hd; v.nt = nt; v.rdy = rdy;
        v.vld = vld; v.typ = typ; v.dat = dat; v.md = md; v.bz = bz;
        tbl.push_back(v);
    endfunction

    function automatic void strobe(input logic hv, input command_e ht, input logic [15:0] hd,
                                   input logic nt, input logic rdy, input command_e typ,
                                   input logic [15:0] dat, input logic [1:0] md);
        add(hv, ht, hd, nt, rdy, 1'b1, typ, dat, md, 1'b1);
    endfunction

    function automatic void idle(input int n, input logic hv, input command_e ht,
                                 input logic [15:0] hd, input logic nt,
                                 input logic [1:0] md, input logic bz);
        for (int k = 0; k < n; k++) add(hv, ht, hd, nt, 1'b0, 1'b0, CMD_OFF, 16'd0, md, bz);
    endfunction

    // Four cycles after a strobe: three still in GAP, then back in IDLE.
    function automatic void gap(input logic hv, input command_e ht, input logic [15:0] hd,
                                input logic nt, input logic [1:0] md);
        idle(3, hv, ht, hd, nt, md, 1'b1);
        idle(1, hv, ht, hd, nt, md, 1'b0);
    endfunction

    task automatic apply_row(input int i);
        vec_t v;
        v = tbl[i];
        bus.host_valid = v.hv;
        bus.host_type  = v.ht;
        bus.host_data  = v.hd;
        night          = v.nt;
        @(negedge clk); #1;
        check($sformatf("r%0d host_ready", i), 32'(bus.host_ready), 32'(v.rdy));
        @(posedge clk); #1;
        check($sformatf("r%0d cmd_valid", i), 32'(bus.cmd_valid), 32'(v.vld));
        if (v.vld) begin
            check($sformatf("r%0d cmd_type", i), 32'(bus.cmd_type), 32'(v.typ));
            check($sformatf("r%0d cmd_data", i), 32'(bus.cmd_data), 32'(v.dat));
        end
        check($sformatf("r%0d mode", i), 32'(mode), 32'(v.md));
        check($sformatf("r%0d busy", i), 32'(busy), 32'(v.bz));
        n_vec++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " host_ready"}, 32'(bus.host_ready), 32'd0);
        check({tag, " cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
        check({tag, " cmd_type"}, 32'(bus.cmd_type), 32'(CMD_OFF));
        check({tag, " cmd_data"}, 32'(bus.cmd_data), 32'd0);
        check({tag, " mode"}, 32'(mode), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd1);
        n_vec++;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // Boot: strobes every 5 cycles, IDLE four cycles after the ON strobe.
        strobe(1'b0, CMD_OFF, 16'd0, 1'b0, 1'b0, CMD_SET_GREEN, 16'd10000, 2'd0);
        idle(4, 1'b0, CMD_OFF, 16'd0, 1'b0, 2'd0, 1'b1);
        strobe(1'b0, CMD_OFF, 16'd0, 1'b0, 1'b0, CMD_SET_RED, 16'd10000, 2'd0);
        idle(4, 1'b0, CMD_OFF, 16'd0, 1'b0, 2'd0, 1'b1);
        strobe(1'b0, CMD_OFF, 16'd0, 1'b0, 1'b0, CMD_SET_YELLOW, 16'd2000, 2'd0);
        idle(4, 1'b0, CMD_OFF, 16'd0, 1'b0, 2'd0, 1'b1);
        strobe(1'b0, CMD_OFF, 16'd0, 1'b0, 1'b0, CMD_ON, 16'd0, 2'd1);
        gap(1'b0, CMD_OFF, 16'd0, 1'b0, 2'd1);

        // Host command, then a second one held through the gap.
        strobe(1'b1, CMD_SET_RED, 16'd3000, 1'b0, 1'b1, CMD_SET_RED, 16'd3000, 2'd1);
        gap(1'b1, CMD_SET_GREEN, 16'd500, 1'b0, 2'd1);
        strobe(1'b1, CMD_SET_GREEN, 16'd500, 1'b0, 1'b1, CMD_SET_GREEN, 16'd500, 2'd1);
        gap(1'b0, CMD_OFF, 16'd0, 1'b0, 2'd1);

        // night_i rise: NOTRANSITION on the third edge; fall: ON.
        idle(2, 1'b0, CMD_OFF, 16'd0, 1'b1, 2'd1, 1'b0);
        strobe(1'b0, CMD_OFF, 16'd0, 1'b1, 1'b0, CMD_NOTRANSITION, 16'd0, 2'd2);
        gap(1'b0, CMD_OFF, 16'd0, 1'b1, 2'd2);
        idle(2, 1'b0, CMD_OFF, 16'd0, 1'b0, 2'd2, 1'b0);
        strobe(1'b0, CMD_OFF, 16'd0, 1'b0, 1'b0, CMD_ON, 16'd0, 2'd1);
        gap(1'b0, CMD_OFF, 16'd0, 1'b0, 2'd1);

        // Host granted last, then conflicts: night, host, night.
        strobe(1'b1, CMD_SET_YELLOW, 16'd1500, 1'b0, 1'b1, CMD_SET_YELLOW, 16'd1500, 2'd1);
        gap(1'b0, CMD_OFF, 16'd0, 1'b0, 2'd1);
        idle(2, 1'b0, CMD_OFF, 16'd0, 1'b1, 2'd1, 1'b0);
        strobe(1'b1, CMD_SET_GREEN, 16'd700, 1'b1, 1'b0, CMD_NOTRANSITION, 16'd0, 2'd2);
        gap(1'b1, CMD_SET_GREEN, 16'd700, 1'b0, 2'd2);
        strobe(1'b1, CMD_SET_GREEN, 16'd700, 1'b0, 1'b1, CMD_SET_GREEN, 16'd700, 2'd2);
        gap(1'b0, CMD_OFF, 16'd0, 1'b0, 2'd2);
        strobe(1'b1, CMD_SET_RED, 16'd800, 1'b0, 1'b0, CMD_ON, 16'd0, 2'd1);
        gap(1'b1, CMD_SET_RED, 16'd800, 1'b0, 2'd1);
        strobe(1'b1, CMD_SET_RED, 16'd800, 1'b0, 1'b1, CMD_SET_RED, 16'd800, 2'd1);
        gap(1'b0, CMD_OFF, 16'd0, 1'b0, 2'd1);

        // Host OFF while night is held: night re-issues NOTRANSITION after the gap.
        idle(2, 1'b0, CMD_OFF, 16'd0, 1'b1, 2'd1, 1'b0);
        strobe(1'b0, CMD_OFF, 16'd0, 1'b1, 1'b0, CMD_NOTRANSITION, 16'd0, 2'd2);
        gap(1'b0, CMD_OFF, 16'd0, 1'b1, 2'd2);
        strobe(1'b1, CMD_OFF, 16'd0, 1'b1, 1'b1, CMD_OFF, 16'd0, 2'd0);
        gap(1'b0, CMD_OFF, 16'd0, 1'b1, 2'd0);
        strobe(1'b0, CMD_OFF, 16'd0, 1'b1, 1'b0, CMD_NOTRANSITION, 16'd0, 2'd2);

        // One-cycle night_i dip inside the gap: level restored before grant, nothing issued.
        add(1'b0, CMD_OFF, 16'd0, 1'b0, 1'b0, 1'b0, CMD_OFF, 16'd0, 2'd2, 1'b1);
        idle(2, 1'b0, CMD_OFF, 16'd0, 1'b1, 2'd2, 1'b1);
        idle(1, 1'b0, CMD_OFF, 16'd0, 1'b1, 2'd2, 1'b0);
        idle(3, 1'b0, CMD_OFF, 16'd0, 1'b1, 2'd2, 1'b0);
        strobe(1'b1, CMD_SET_YELLOW, 16'd900, 1'b1, 1'b1, CMD_SET_YELLOW, 16'd900, 2'd2);

        arst_n         = 1'b0;
        night          = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_type  = CMD_ON;
        bus.host_data  = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        bus.host_valid = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply_row(i);

        // Reset pulsed while the host strobe is still high: outputs clear at once.
        arst_n         = 1'b0;
        bus.host_valid = 1'b1;
        #1;
        check_reset_state("mid_gap_reset");
        bus.host_valid = 1'b0;
        night          = 1'b0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        for (int i = 0; i < BOOT_ROWS; i++) apply_row(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
